dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder that sits on the memory side of the pipeline's MEM stage and serves its load/store requests. It accepts one request at a time and holds the pipeline with `stall` while the access is in progress. It performs the word access after a configurable latency and returns read data with a one-cycle response pulse. It replaces the single-cycle data memory model, so the hazard and stall path can be exercised against realistic memory latency.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words; must be a power of two, ≥ 4.
- `LATENCY`, 2: number of BUSY cycles per access; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; everything is updated on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present; driven from EX/MEM `memRead | memWrite`.
- `req_write`  in  1  1 = store, 0 = load; sampled only on acceptance.
- `req_addr`  in  32  byte address (the EX/MEM ALU result).
- `req_wdata`  in  32  store data.
- `req_ready`  out  1  responder can accept a request this cycle.
- `stall`  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM.
- `resp_valid`  out  1  response pulse; lasts one cycle.
- `resp_rdata`  out  32  load data; valid while `resp_valid` = 1.
- `resp_err`  out  1  access fault; valid while `resp_valid` = 1.

## Operation
- The state machine has three states: IDLE, BUSY and RESP. A down-counter of width clog2(LATENCY+1) runs during BUSY.
- IDLE:
  - `req_ready` = 1.
  - When `req_valid` = 1, the request is accepted: latch `req_write`, `req_addr` and `req_wdata`, load the counter with LATENCY-1, and go to BUSY.
- BUSY:
  - `req_ready` = 0. Request inputs are ignored.
  - The counter decrements each cycle.
  - In the cycle where the counter = 0, the access happens at the closing edge and the state goes to RESP:
    - Store: write the latched data into `mem[idx]`.
    - Load: register `mem[idx]` into `resp_rdata`.
- RESP:
  - `resp_valid` = 1 and `req_ready` = 0. Go to IDLE unconditionally.
  - During RESP the pipeline advances, so the same request is not seen again.
- Word index `idx` = `addr[clog2(DEPTH)+1:2]`.
- `stall` = (IDLE & `req_valid`) | BUSY. It is 0 in RESP.
- After a store, `resp_rdata` holds the value of `mem[idx]` read before the write; consumers ignore it.
- A read of a location returns the most recent completed write to it. There is no concurrency, because only one request is outstanding.

## Timing
- Reset values:
  - State IDLE and counter 0.
  - `req_ready` = 1 in the cycle after reset. While `rst` is high, `req_ready` = 0 and `stall` = 0.
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - All memory words are cleared to 0.
- Acceptance in cycle T gives:
  - BUSY for cycles T+1 … T+LATENCY.
  - RESP in cycle T+LATENCY+1.
  - `stall` high for LATENCY+1 cycles (T … T+LATENCY).
- Back-to-back accesses have a minimum spacing of LATENCY+2 cycles, because `req_ready` is low in RESP.
- Reset in BUSY or RESP: the access is aborted, a pending store is discarded, and no `resp_valid` is issued.
- `req_valid` dropping during BUSY is ignored; the latched access completes.
- `resp_rdata` and `resp_err` are registered outputs. They hold their values until the next access completes.

## Configuration
- `DMEM_FAULT_CHECK_EN` defined:
  - An access faults if it is misaligned (`addr[1:0]` ≠ 0) or out of range (`addr` ≥ 4·DEPTH).
  - On a fault: `resp_err` = 1 in RESP, the store is suppressed, and `resp_rdata` = 0. Timing is unchanged.
- `DMEM_FAULT_CHECK_EN` undefined:
  - `addr[1:0]` and the upper bits are ignored, so the index wraps modulo DEPTH.
  - `resp_err` is tied to 0.

## Test plan
- Reset, then idle, with LATENCY = 2:
  - Expect `req_ready` = 1, `stall` = 0, `resp_valid` = 0, `resp_rdata` = 0.
- Store 0xDEADBEEF to 0x10, then load 0x10:
  - The store gives `stall` = 1 for 3 cycles and `resp_valid` in the 4th cycle.
  - The load returns 0xDEADBEEF with `resp_err` = 0.
- Load from never-written address 0x40 after reset:
  - Expect `resp_rdata` = 0 at cycle T+3.
- Assert `rst` during BUSY of a store of 0x12345678 to 0x20, then load 0x20:
  - The aborted store produces no `resp_valid`.
  - The later load returns 0.
- With LATENCY = 1, issue two loads back to back:
  - Acceptances fall at cycles T and T+3.
  - `resp_valid` appears at T+2 and T+5.
- `DMEM_FAULT_CHECK_EN` defined, store 0x55 to address 0x13 (misaligned):
  - Expect `resp_err` = 1.
  - A load of 0x10 returns its previous value.
  - A load of 4·DEPTH gives `resp_err` = 1 and `resp_rdata` = 0.
  - With the macro undefined, the same store writes word 4 and `resp_err` = 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, LATENCY busy cycles, one-cycle response pulse.
// Define DMEM_FAULT_CHECK_EN to flag misaligned or out-of-range accesses through resp_err.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           write_q, write_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           fault_q, fault_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           mem_we;
    logic           req_fault;
    logic [31:0]    mem_q [DEPTH];

`ifdef DMEM_FAULT_CHECK_EN
    assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
`else
    // Byte-offset and upper address bits are deliberately dropped so the index wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
    assign req_fault        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        fault_d    = fault_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        req_ready  = 1'b0;
        stall      = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_addr[AW+1:2];
                    wdata_d = req_wdata;
                    fault_d = req_fault;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    // Stores also capture the pre-write word; consumers ignore it.
                    rdata_d = fault_q ? 32'h0 : mem_q[idx_q];
                    err_d   = fault_q;
                    mem_we  = write_q & ~fault_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            req_ready  = 1'b0;
            stall      = 1'b0;
            resp_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Reset has priority, so a store completing in the reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder: a transaction-level memory model predicts
// handshake timing and response data; a separate monitor pops expectations on resp_valid.
module tb_dmem_responder;

    localparam int DEPTH = 32;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cycle;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       expQ[$];
    logic [31:0] model [DEPTH];
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;
    int          freeAt = 0;
    int          busyFrom = -1;
    int          busyTo = -1;
    int          respAt = -1;
    logic [31:0] respRdata;
    logic        respErr;
    logic        pendWrite = 1'b0;
    int          pendIdx;
    logic [31:0] pendData;
    int          pendDone;
    logic [31:0] heldRdata = '0;
    logic        heldErr = 1'b0;
    logic        heldKnown = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cycle, actual, expected);
        end
    endtask

    always @(posedge clk) cycle++;

    // Transaction-level model: a word array plus the acceptance/busy/response windows.
    always @(negedge clk) begin
        logic        expReady;
        logic        inBusy;
        logic        fault;
        int          idx;
        resp_t       r;
        if (rst) begin
            checkOutput("ready_in_reset", {31'b0, req_ready}, 32'd0);
            checkOutput("stall_in_reset", {31'b0, stall}, 32'd0);
            checkOutput("resp_valid_in_reset", {31'b0, resp_valid}, 32'd0);
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            expQ.delete();
            pendWrite = 1'b0;
            freeAt    = cycle + 1;
            busyFrom  = -1;
            busyTo    = -1;
            respAt    = -1;
            heldRdata = '0;
            heldErr   = 1'b0;
            heldKnown = 1'b1;
        end else begin
            if (pendWrite && cycle > pendDone) begin
                model[pendIdx] = pendData;
                pendWrite      = 1'b0;
            end
            if (cycle == respAt) begin
                heldRdata = respRdata;
                heldErr   = respErr;
            end
            expReady = (cycle >= freeAt);
            inBusy   = (cycle >= busyFrom) && (cycle <= busyTo);
            checkOutput("req_ready", {31'b0, req_ready}, {31'b0, expReady});
            checkOutput("stall", {31'b0, stall}, {31'b0, (expReady && req_valid) || inBusy});
            if (heldKnown) begin
                checkOutput("resp_rdata_held", resp_rdata, heldRdata);
                checkOutput("resp_err_held", {31'b0, resp_err}, {31'b0, heldErr});
            end
            if (expReady && req_valid) begin
                idx = int'((req_addr >> 2) % DEPTH);
`ifdef DMEM_FAULT_CHECK_EN
                fault = (req_addr % 4 != 0) || (req_addr >= 32'(4 * DEPTH));
`else
                fault = 1'b0;
`endif
                r.cycle = cycle + LAT + 1;
                r.rdata = fault ? 32'h0 : model[idx];
                r.err   = fault;
                expQ.push_back(r);
                if (req_write && !fault) begin
                    pendWrite = 1'b1;
                    pendIdx   = idx;
                    pendData  = req_wdata;
                    pendDone  = cycle + LAT;
                end
                respRdata = r.rdata;
                respErr   = r.err;
                respAt    = r.cycle;
                busyFrom  = cycle + 1;
                busyTo    = cycle + LAT;
                freeAt    = cycle + LAT + 2;
            end
        end
    end

    // Response monitor: every resp_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        resp_t r;
        if (resp_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp at cycle %0d: got resp_valid=1, expected 0", cycle);
            end else begin
                r = expQ.pop_front();
                checkOutput("resp_cycle", 32'(cycle), 32'(r.cycle));
                checkOutput("resp_rdata", resp_rdata, r.rdata);
                checkOutput("resp_err", {31'b0, resp_err}, {31'b0, r.err});
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input int n);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pipeline-like access: valid held through BUSY and RESP, then the next request follows.
    task automatic doAccess(input logic w, input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b1, w, a, d, LAT + 2);
    endtask

    task automatic pulseReset(input int n);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, n);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3);
        doAccess(1'b1, 32'h10, 32'hDEADBEEF);
        doAccess(1'b0, 32'h10, 32'h0);
        pulseReset(2);
        doAccess(1'b0, 32'h40, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h12345678, 2);
        pulseReset(1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1);
        doAccess(1'b0, 32'h20, 32'h0);
        doAccess(1'b1, 32'h10, 32'hDEADBEEF);
        doAccess(1'b1, 32'h13, 32'h55);
        doAccess(1'b0, 32'h10, 32'h0);
        doAccess(1'b0, 32'(4 * DEPTH), 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h24, 32'hCAFE0001, 1);
        applyStimulus(1'b0, 1'b0, 32'h28, 32'h0, 1);
        applyStimulus(1'b1, 1'b0, 32'h2C, 32'h0, 2);
        doAccess(1'b0, 32'h24, 32'h0);

        for (int i = 0; i < 1500; i++) begin
            case ($urandom % 8)
                0:       a = $urandom;
                1:       a = ($urandom % 64) * 4 + ($urandom % 4);
                default: a = ($urandom % (2 * DEPTH)) * 4;
            endcase
            rst = ($urandom % 80 == 0);
            applyStimulus(($urandom % 3) != 0, $urandom % 2, a, $urandom, 1);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, LAT + 4);

        checkOutput("outstanding_responses", 32'(expQ.size()), 32'd0);
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
